rr_arb_8_1: RTL and testbench

RR_ARB_8_1 -- requirements
Module: rr_arb_8_1

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick_8.sv | 26 ++
 rtl/rr_arb_8_1.sv | 104 ++++++++++
 tb/tb_rr_arb_8_1.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM states,
// requester count and the default data width.
package arb_pkg;

  localparam int N = 8;
  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick_8.sv
// Rotating-priority search over 8 requests, starting at ptr and wrapping,
// reporting whether anyone requested and the first index found.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       any,
  output logic [2:0] idx
);

  // Scan ptr, ptr+1, ... with 3-bit wraparound; the first hit wins.
  always_comb begin
    any = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < N; i++) begin
      logic [2:0] k;
      k = ptr + 3'(i);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/rr_arb_8_1.sv
// 8-to-1 round-robin arbiter with a registered valid/ready output stage.
// The requester just served drops to lowest priority at the next arbitration.
module rr_arb_8_1
  import arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       s,
  output logic [7:0]       gnt
);

  state_t           state, next_state;
  logic [2:0]       ptr, next_ptr;
  logic [2:0]       next_s;
  logic [7:0]       next_gnt;
  logic [WIDTH-1:0] next_y;
  logic             next_valid;

  logic             any;
  logic [2:0]       idx;
  logic [WIDTH-1:0] sel_data;
  logic             arbitrate;

  rr_pick_8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );

  always_comb begin
    sel_data = d0;
    case (idx)
      3'd0: sel_data = d0;
      3'd1: sel_data = d1;
      3'd2: sel_data = d2;
      3'd3: sel_data = d3;
      3'd4: sel_data = d4;
      3'd5: sel_data = d5;
      3'd6: sel_data = d6;
      3'd7: sel_data = d7;
      default: sel_data = d0;
    endcase
  end

  // A held word blocks arbitration until it is accepted downstream.
  assign arbitrate = (state == IDLE) || ready;

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_s     = s;
    next_gnt   = gnt;
    next_y     = y;
    next_valid = valid;
    if (arbitrate) begin
      if (any) begin
        next_state = BUSY;
        next_ptr   = idx + 3'd1;
        next_s     = idx;
        next_gnt   = 8'd1 << idx;
        next_y     = sel_data;
        next_valid = 1'b1;
      end else begin
        next_state = IDLE;
        next_gnt   = 8'd0;
        next_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd0;
      s     <= 3'd0;
      gnt   <= 8'd0;
      y     <= '0;
      valid <= 1'b0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      s     <= next_s;
      gnt   <= next_gnt;
      y     <= next_y;
      valid <= next_valid;
    end
  end

endmodule

// File: tb/tb_rr_arb_8_1.sv
// Directed self-checking bench for rr_arb_8_1 with hand-computed grants.
module tb_rr_arb_8_1;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [2:0] d [8];
  logic       ready;
  logic       valid;
  logic [2:0] y;
  logic [2:0] s;
  logic [7:0] gnt;

  int checks;
  int errors;

  rr_arb_8_1 #(.WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .d0    (d[0]),
    .d1    (d[1]),
    .d2    (d[2]),
    .d3    (d[3]),
    .d4    (d[4]),
    .d5    (d[5]),
    .d6    (d[6]),
    .d7    (d[7]),
    .ready (ready),
    .valid (valid),
    .y     (y),
    .s     (s),
    .gnt   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [2:0] ey,
                            input logic [2:0] es, input logic [7:0] eg);
    check_output({tag, ".valid"}, 32'(valid), 32'(v));
    check_output({tag, ".y"},     32'(y),     32'(ey));
    check_output({tag, ".s"},     32'(s),     32'(es));
    check_output({tag, ".gnt"},   32'(gnt),   32'(eg));
  endtask

  task automatic expect_grant(input string tag, input logic [2:0] k, input logic [2:0] ey);
    expect_all(tag, 1'b1, ey, k, 8'd1 << k);
  endtask

  task automatic apply_stimulus(input logic [7:0] r, input logic rd);
    req   = r;
    ready = rd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 8'h00;
    ready  = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = 3'(i);
    #2;
    expect_all("reset", 1'b0, 3'd0, 3'd0, 8'h00);
    #10;
    reset = 1'b0;

    // No requests: stays idle with cleared outputs.
    for (int i = 0; i < 5; i++) begin
      step();
      expect_all("idle", 1'b0, 3'd0, 3'd0, 8'h00);
    end

    // All requesting with ready high: 0..7 then wrap to 0, no bubbles.
    apply_stimulus(8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      expect_grant("allreq", 3'(i % 8), 3'(i % 8));
    end

    // Drain to idle; ptr stays at 1, y and s hold.
    apply_stimulus(8'h00, 1'b1);
    step();
    expect_all("drain", 1'b0, 3'd0, 3'd0, 8'h00);

    // Two requesters with backpressure.
    apply_stimulus(8'b0010_0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("hold2", 3'd2, 3'b010);
    end
    ready = 1'b1;
    step();
    expect_grant("next5", 3'd5, 3'b101);

    // Grant 3, then its request drops and its data changes while waiting.
    apply_stimulus(8'b0000_1000, 1'b1);
    step();
    expect_grant("grant3", 3'd3, 3'b011);
    apply_stimulus(8'h00, 1'b0);
    d[3] = 3'b000;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_grant("keep3", 3'd3, 3'b011);
    end
    ready = 1'b1;
    step();
    expect_all("after3", 1'b0, 3'b011, 3'd3, 8'h00);
    d[3] = 3'd3;

    // Grant 6 leaves ptr at 7; then 7 and 0 compete: 7 first, then wrap to 0.
    apply_stimulus(8'b0100_0000, 1'b1);
    step();
    expect_grant("grant6", 3'd6, 3'd6);
    apply_stimulus(8'b1000_0001, 1'b1);
    step();
    expect_grant("wrap7", 3'd7, 3'd7);
    step();
    expect_grant("wrap0", 3'd0, 3'd0);

    // Busy on 4, then reset between edges clears outputs at once.
    apply_stimulus(8'b0001_0000, 1'b1);
    step();
    expect_grant("grant4", 3'd4, 3'd4);
    ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    expect_all("rstmid", 1'b0, 3'd0, 3'd0, 8'h00);
    #1;
    reset = 1'b0;
    step();
    expect_grant("postrst4", 3'd4, 3'd4);

    // After another mid-busy reset, ptr restarts at 0 so 0 beats 7.
    #3;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    apply_stimulus(8'b1000_0001, 1'b0);
    step();
    expect_grant("ptr0", 3'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
